tile_pingpong_buffer: RTL and testbench

//   Double-banked (ping-pong) tile buffer for the matrix-multiplication datapath.
//   A producer streams one tile of TILE_SIZE words into one bank while a consumer drains the other bank.

---
 rtl/tile_pingpong_buffer.sv | 136 +++++++++++++
 tb/tb_tile_pingpong_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_pingpong_buffer.sv
// tile_pingpong_buffer
//   Two-bank tile buffer. The producer fills one bank while the consumer drains
//   the other. Each stored tile is replayed (replay+1) times before its bank is
//   released back to the producer. All status outputs decode registered state.
module tile_pingpong_buffer #(
  parameter int DATA_WIDTH = 12,
  parameter int TILE_SIZE  = 4,
  parameter int REPLAY_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [REPLAY_W-1:0]   wr_replay,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_tile_done,
  output logic [1:0]            tiles_avail
);

  localparam int IW = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(TILE_SIZE - 1);

  // Storage and bank state
  logic [DATA_WIDTH-1:0] mem_r [2][TILE_SIZE];
  logic [1:0]            full_r;
  logic [REPLAY_W-1:0]   replay_r [2];

  // Pointers
  logic                  wr_bank_r;
  logic [IW-1:0]         wr_idx_r;
  logic                  rd_bank_r;
  logic [IW-1:0]         rd_idx_r;
  logic [REPLAY_W-1:0]   pass_cnt_r;

  // Handshake decode
  logic wr_fire_s;
  logic wr_end_s;
  logic rd_fire_s;
  logic rd_done_s;

  assign wr_ready  = !full_r[wr_bank_r];
  assign rd_valid  = full_r[rd_bank_r];
  assign wr_fire_s = wr_valid && wr_ready;
  assign wr_end_s  = wr_fire_s && (wr_idx_r == LAST_IDX);
  assign rd_fire_s = rd_valid && rd_ready;

  // rd_idx only leaves 0 while the read bank is full, so the valid gate just
  // keeps the flags quiet on an empty buffer.
  assign rd_last      = rd_valid && (rd_idx_r == LAST_IDX);
  assign rd_tile_done = rd_last && (pass_cnt_r == replay_r[rd_bank_r]);
  assign rd_done_s    = rd_fire_s && rd_tile_done;

  // Memory is never cleared; gating with rd_valid keeps rd_data X-free.
  assign rd_data     = rd_valid ? mem_r[rd_bank_r][rd_idx_r] : '0;
  assign tiles_avail = {1'b0, full_r[0]} + {1'b0, full_r[1]};

  // Tile storage: written on every accepted producer word, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_r[wr_bank_r][wr_idx_r] <= wr_data;
    end
  end

  // Write pointer and per-bank replay count latched on the tile's last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_r   <= 1'b0;
      wr_idx_r    <= '0;
      replay_r[0] <= '0;
      replay_r[1] <= '0;
    end else if (flush) begin
      wr_bank_r   <= 1'b0;
      wr_idx_r    <= '0;
      replay_r[0] <= '0;
      replay_r[1] <= '0;
    end else if (wr_end_s) begin
      replay_r[wr_bank_r] <= wr_replay;
      wr_idx_r            <= '0;
      wr_bank_r           <= !wr_bank_r;
    end else if (wr_fire_s) begin
      wr_idx_r <= wr_idx_r + IW'(1);
    end else begin
      wr_idx_r <= wr_idx_r;
    end
  end

  // Read pointer: wrap per pass, release bank after the final pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank_r  <= 1'b0;
      rd_idx_r   <= '0;
      pass_cnt_r <= '0;
    end else if (flush) begin
      rd_bank_r  <= 1'b0;
      rd_idx_r   <= '0;
      pass_cnt_r <= '0;
    end else if (rd_done_s) begin
      rd_idx_r   <= '0;
      pass_cnt_r <= '0;
      rd_bank_r  <= !rd_bank_r;
    end else if (rd_fire_s && rd_last) begin
      rd_idx_r   <= '0;
      pass_cnt_r <= pass_cnt_r + REPLAY_W'(1);
    end else if (rd_fire_s) begin
      rd_idx_r <= rd_idx_r + IW'(1);
    end else begin
      rd_idx_r <= rd_idx_r;
    end
  end

  // Bank full flags: set by a completing write, cleared by a releasing read.
  // Both can happen in one cycle because they always address different banks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_r <= 2'b00;
    end else if (flush) begin
      full_r <= 2'b00;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (wr_end_s && (wr_bank_r == 1'(b))) begin
          full_r[b] <= 1'b1;
        end else if (rd_done_s && (rd_bank_r == 1'(b))) begin
          full_r[b] <= 1'b0;
        end else begin
          full_r[b] <= full_r[b];
        end
      end
    end
  end

endmodule

// File: tb/tb_tile_pingpong_buffer.sv
// Directed bench for tile_pingpong_buffer with a small reference model:
// a producer queue, an expected-read queue expanded by replay count, and a
// tile counter that predicts tiles_avail / wr_ready / rd_valid.
module tb_tile_pingpong_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [11:0] wr_data = '0;
  logic [3:0]  wr_replay = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [11:0] rd_data;
  logic        rd_last;
  logic        rd_tile_done;
  logic [1:0]  tiles_avail;

  tile_pingpong_buffer #(.DATA_WIDTH(12), .TILE_SIZE(4), .REPLAY_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_replay(wr_replay),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .rd_tile_done(rd_tile_done), .tiles_avail(tiles_avail)
  );

  always #5 clk = !clk;

  typedef struct packed { logic [11:0] d; logic [3:0] rep; } wr_item_t;
  typedef struct packed { logic [11:0] d; logic last; logic done; } rd_item_t;

  wr_item_t    wq[$];
  rd_item_t    exp_q[$];
  logic [11:0] cur[$];
  int          model_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_reads = 0;
  int          n_last = 0;
  int          n_done = 0;
  logic        hold_valid = 1'b0;
  logic [11:0] hold_data = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic push_tile(input logic [11:0] a, input logic [11:0] b,
                           input logic [11:0] c, input logic [11:0] d, input logic [3:0] rep);
    wq.push_back('{d: a, rep: rep});
    wq.push_back('{d: b, rep: rep});
    wq.push_back('{d: c, rep: rep});
    wq.push_back('{d: d, rep: rep});
  endtask

  task automatic clear_model();
    exp_q.delete();
    cur.delete();
    model_cnt  = 0;
    hold_valid = 1'b0;
  endtask

  // One clock: drive at negedge, check at negedge+1, update model after posedge.
  task automatic step(input bit wen, input int rmode, input bit fl);
    logic rfire, wfire, done_now;
    logic [11:0] wd_now;
    logic [3:0]  wrep_now;
    @(negedge clk);
    wr_valid  = wen && (wq.size() > 0);
    wr_data   = (wq.size() > 0) ? wq[0].d : 12'd0;
    wr_replay = (wq.size() > 0) ? wq[0].rep : 4'd0;
    rd_ready  = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
    flush     = fl;
    #1;
    check_eq("tiles_avail", 32'(tiles_avail), 32'(model_cnt));
    check_eq("wr_ready", 32'(wr_ready), 32'(model_cnt != 2));
    check_eq("rd_valid", 32'(rd_valid), 32'(model_cnt != 0));
    if (hold_valid && rd_valid) check_eq("stall_hold", 32'(rd_data), 32'(hold_data));
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("rd_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        check_eq("rd_data", 32'(rd_data), 32'(exp_q[0].d));
        check_eq("rd_last", 32'(rd_last), 32'(exp_q[0].last));
        check_eq("rd_tile_done", 32'(rd_tile_done), 32'(exp_q[0].done));
      end
    end
    rfire    = rd_valid && rd_ready && !fl;
    wfire    = wr_valid && wr_ready && !fl;
    done_now = rd_tile_done;
    wd_now   = wr_data;
    wrep_now = wr_replay;
    hold_valid = rd_valid && !rd_ready && !fl;
    hold_data  = rd_data;
    if (rfire) begin
      n_reads++;
      if (rd_last) n_last++;
      if (rd_tile_done) n_done++;
    end
    @(posedge clk);
    if (fl) begin
      clear_model();
    end else begin
      if (rfire && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        if (done_now) model_cnt--;
      end
      if (wfire) begin
        void'(wq.pop_front());
        cur.push_back(wd_now);
        if (cur.size() == 4) begin
          for (int p = 0; p <= int'(wrep_now); p++)
            for (int i = 0; i < 4; i++)
              exp_q.push_back('{d: cur[i], last: (i == 3), done: (i == 3 && p == int'(wrep_now))});
          cur.delete();
          model_cnt++;
        end
      end
    end
  endtask

  task automatic run(input int budget, input bit wen, input int rmode);
    for (int n = 0; n < budget; n++) begin
      if (wq.size() == 0 && exp_q.size() == 0 && cur.size() == 0) break;
      step(wen, rmode, 1'b0);
    end
  endtask

  task automatic reset_counts();
    n_reads = 0; n_last = 0; n_done = 0;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
    check_eq({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check_eq({tag, "_rd_last"}, 32'(rd_last), 32'd0);
    check_eq({tag, "_rd_done"}, 32'(rd_tile_done), 32'd0);
    check_eq({tag, "_tiles"}, 32'(tiles_avail), 32'd0);
    check_eq({tag, "_data_x"}, 32'($isunknown(rd_data)), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0; flush = 1'b0;
    #1;
    check_idle("rst");
    wq.delete();
    clear_model();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();

    // 1: single tile, single pass
    reset_counts();
    push_tile(12'd1, 12'd2, 12'd3, 12'd4, 4'd0);
    run(20, 1'b1, 1);
    check_eq("t1_reads", 32'(n_reads), 32'd4);
    check_eq("t1_done", 32'(n_done), 32'd1);

    // 2: fill both banks with consumer stalled, 9th word held off
    reset_counts();
    push_tile(12'd10, 12'd11, 12'd12, 12'd13, 4'd0);
    push_tile(12'd20, 12'd21, 12'd22, 12'd23, 4'd0);
    wq.push_back('{d: 12'd99, rep: 4'd0});
    for (int n = 0; n < 12; n++) step(1'b1, 0, 1'b0);
    check_eq("t2_tiles_full", 32'(tiles_avail), 32'd2);
    check_eq("t2_wr_ready", 32'(wr_ready), 32'd0);
    check_eq("t2_held_off", 32'(wq.size()), 32'd1);
    wq.delete();
    run(30, 1'b0, 1);
    check_eq("t2_reads", 32'(n_reads), 32'd8);

    // 3: replay of 2 -> three passes
    reset_counts();
    push_tile(12'd5, 12'd6, 12'd7, 12'd8, 4'd2);
    run(40, 1'b1, 1);
    check_eq("t3_reads", 32'(n_reads), 32'd12);
    check_eq("t3_last", 32'(n_last), 32'd3);
    check_eq("t3_done", 32'(n_done), 32'd1);

    // 4: continuous streaming of four tiles
    reset_counts();
    for (int t = 0; t < 4; t++)
      push_tile(12'(100 + 4 * t), 12'(101 + 4 * t), 12'(102 + 4 * t), 12'(103 + 4 * t), 4'd0);
    run(80, 1'b1, 1);
    check_eq("t4_reads", 32'(n_reads), 32'd16);
    check_eq("t4_drained", 32'(exp_q.size() + wq.size()), 32'd0);

    // 5: random consumer backpressure with mixed replay counts
    reset_counts();
    push_tile(12'h201, 12'h202, 12'h203, 12'h204, 4'd1);
    push_tile(12'h301, 12'h302, 12'h303, 12'h304, 4'd0);
    push_tile(12'hABC, 12'h123, 12'hFFF, 12'h000, 4'd1);
    run(400, 1'b1, 2);
    check_eq("t5_reads", 32'(n_reads), 32'd20);
    check_eq("t5_done", 32'(n_done), 32'd3);

    // 6a: flush after two writes, then a fresh tile
    push_tile(12'd30, 12'd31, 12'd32, 12'd33, 4'd0);
    step(1'b1, 0, 1'b0);
    step(1'b1, 0, 1'b0);
    step(1'b0, 0, 1'b1);
    wq.delete();
    @(negedge clk);
    #1;
    check_idle("flush");
    reset_counts();
    push_tile(12'd9, 12'd9, 12'd9, 12'd9, 4'd0);
    run(20, 1'b1, 1);
    check_eq("t6a_reads", 32'(n_reads), 32'd4);

    // 6b: reset in the middle of a replayed read, then a fresh tile
    push_tile(12'd40, 12'd41, 12'd42, 12'd43, 4'd1);
    for (int n = 0; n < 7; n++) step(1'b1, 1, 1'b0);
    do_reset();
    reset_counts();
    push_tile(12'd9, 12'd9, 12'd9, 12'd9, 4'd0);
    run(20, 1'b1, 1);
    check_eq("t6b_reads", 32'(n_reads), 32'd4);
    check_eq("t6b_done", 32'(n_done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
